avalon_mm_master: RTL and testbench

AVALON_MM_MASTER -- requirements
Module: avalon_mm_master

---
 rtl/avalon_mm_master_pkg.sv | 14 +
 rtl/avalon_wait_timer.sv | 29 ++
 rtl/avalon_mm_master.sv | 95 +++++++++
 tb/tb_avalon_mm_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mm_master_pkg.sv
// rtl/avalon_mm_master_pkg.sv - shared state encoding and byte-enable constants for the Avalon-MM master
package avalon_mm_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/avalon_wait_timer.sv
// rtl/avalon_wait_timer.sv - counts stalled bus cycles and flags the one that hits the limit
module avalon_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the stalled cycle whose edge brings the count up to the limit,
  // so the strobe is low the cycle after the counter reaches TIMEOUT_CYCLES.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/avalon_mm_master.sv
// rtl/avalon_mm_master.sv - single-outstanding CPU-to-Avalon-MM bridge with stall timeout
module avalon_mm_master
  import avalon_mm_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteen,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_t state, next_state;
  logic   timer_clear, timer_en, expired;

  assign timer_clear = (state == ST_IDLE);
  assign timer_en    = (state == ST_READ || state == ST_WRITE) && waitrequest;

  avalon_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_write)                   next_state = ST_READ;
          else if (req_byteen == BE_NONE)   next_state = ST_RESP;
          else                              next_state = ST_WRITE;
        end
      end
      ST_READ, ST_WRITE: begin
        if (!waitrequest || expired) next_state = ST_RESP;
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    read       = (state == ST_READ);
    write      = (state == ST_WRITE);
    resp_valid = (state == ST_RESP);
  end

  // Bus-side fields are only loaded at acceptance, which keeps them frozen for the whole strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      address    <= '0;
      writedata  <= '0;
      byteenable <= BE_NONE;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (req_ready && req_valid) begin
        address    <= {req_addr[31:2], 2'b00};
        writedata  <= req_wdata;
        byteenable <= req_write ? req_byteen : BE_ALL;
        resp_err   <= 1'b0;
      end
      if (timer_en && expired) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (read && !waitrequest) begin
        resp_rdata <= readdata;
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_master.sv
// tb/tb_avalon_mm_master.sv - self-checking bench with a word-memory slave and transaction-level model
module tb_avalon_mm_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_byteen = '0;
  logic        req_ready, resp_valid, resp_err, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] slave_mem [int];
  logic [31:0] exp_mem [int];

  always #5 clk = ~clk;

  avalon_mm_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] slave_word(input int w);
    return slave_mem.exists(w) ? slave_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    return exp_mem.exists(w) ? exp_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Issue one request and follow it to its response; the expected outcome comes from the request alone.
  task automatic do_txn(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int stalls);
    int w, aw, strobes, c, exp_strobes;
    bit nobus, tmo, got;
    logic [31:0] exp_rdata, aligned;
    w = int'(addr[31:2]);
    aligned = {addr[31:2], 2'b00};
    nobus = wr && (be == 4'b0000);
    tmo = !nobus && (stalls >= T);
    exp_strobes = nobus ? 0 : (tmo ? T : stalls + 1);
    exp_rdata = tmo ? 32'h0 : exp_word(w);
    if (wr && !nobus && !tmo) exp_mem[w] = merge(exp_word(w), wd, be);

    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL %s ready_before: got %b want 1", name, req_ready); end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_byteen = be;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_byteen = 4'($urandom);
    strobes = 0; got = 0; c = 0;
    while (!got && c < 40) begin
      if (resp_valid) begin
        got = 1;
        tests_run++;
        if (c !== exp_strobes) begin tests_failed++; $display("FAIL %s latency: got %0d want %0d", name, c, exp_strobes); end
        tests_run++;
        if (resp_err !== tmo) begin tests_failed++; $display("FAIL %s resp_err: got %b want %b", name, resp_err, tmo); end
        if (!wr || tmo) begin
          tests_run++;
          if (resp_rdata !== exp_rdata) begin tests_failed++; $display("FAIL %s resp_rdata: got %h want %h", name, resp_rdata, exp_rdata); end
        end
      end else if (read || write) begin
        tests_run++;
        if ((read && write) || (write !== wr)) begin tests_failed++; $display("FAIL %s strobe: got r=%b w=%b want w=%b", name, read, write, wr); end
        tests_run++;
        if (address !== aligned) begin tests_failed++; $display("FAIL %s address: got %h want %h", name, address, aligned); end
        tests_run++;
        if (byteenable !== (wr ? be : 4'hF)) begin tests_failed++; $display("FAIL %s byteenable: got %b want %b", name, byteenable, wr ? be : 4'hF); end
        if (wr) begin
          tests_run++;
          if (writedata !== wd) begin tests_failed++; $display("FAIL %s writedata: got %h want %h", name, writedata, wd); end
        end
        aw = int'(address[31:2]);
        waitrequest = (strobes < stalls);
        readdata = waitrequest ? $urandom : slave_word(aw);
        if (write && !waitrequest) slave_mem[aw] = merge(slave_word(aw), writedata, byteenable);
        strobes++;
      end
      @(negedge clk);
      c++;
    end
    waitrequest = 1'b0;
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL %s no_response: got none within 40 cycles want resp_valid", name);
    end else if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s after_resp: got valid=%b ready=%b want 0/1", name, resp_valid, req_ready);
    end
    tests_run++;
    if (strobes !== exp_strobes) begin tests_failed++; $display("FAIL %s strobe_cycles: got %0d want %0d", name, strobes, exp_strobes); end
    tests_run++;
    if (slave_word(w) !== exp_word(w)) begin tests_failed++; $display("FAIL %s memory: got %h want %h", name, slave_word(w), exp_word(w)); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({read, write, resp_valid, resp_err} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {read, write, resp_valid, resp_err}); end
    tests_run++;
    if ({resp_rdata, address, writedata, byteenable} !== 100'h0) begin tests_failed++; $display("FAIL reset_regs: got %h/%h/%h/%b want zeros", resp_rdata, address, writedata, byteenable); end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_directed();
    slave_mem[4] = 32'hDEADBEEF; exp_mem[4] = 32'hDEADBEEF;
    do_txn("read_zero_wait", 1'b0, 32'h10, 32'h0, 4'hF, 0);
    slave_mem[8] = 32'hAABBCCDD; exp_mem[8] = 32'hAABBCCDD;
    do_txn("write_stall3", 1'b1, 32'h22, 32'h11223344, 4'b0101, 3);
    tests_run++;
    if (slave_word(8) !== 32'hAA22CC44) begin tests_failed++; $display("FAIL write_lanes: got %h want aa22cc44", slave_word(8)); end
    do_txn("write_no_lanes", 1'b1, 32'h30, 32'hCAFEF00D, 4'b0000, 0);
    do_txn("read_timeout", 1'b0, 32'h14, 32'h0, 4'hF, 100);
    do_txn("write_timeout", 1'b1, 32'h18, 32'h12345678, 4'hF, T);
    do_txn("read_stall_limit_minus1", 1'b0, 32'h1C, 32'h0, 4'hF, T - 1);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3C; req_wdata = 32'h0BADF00D; req_byteen = 4'hF;
    waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if (write !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_write_started: got %b want 1", write); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({write, read, resp_valid} !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_strobes: got w=%b r=%b v=%b want 000", write, read, resp_valid); end
    reset = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    repeat (3) begin
      tests_run++;
      if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_resp: got %b want 0", resp_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int first, second, overlaps;
    bit switch_now, stop_now, seen_read_resp;
    first = -1; second = -1; overlaps = 0; switch_now = 0; stop_now = 0; seen_read_resp = 0;
    exp_mem[2] = merge(exp_word(2), 32'h55667788, 4'hF);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; req_byteen = 4'hF; waitrequest = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (switch_now) begin req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h55667788; switch_now = 0; end
      if (stop_now) begin req_valid = 1'b0; stop_now = 0; end
      if (read && write) overlaps++;
      if (read) readdata = slave_word(int'(address[31:2]));
      if (write) slave_mem[int'(address[31:2])] = merge(slave_word(int'(address[31:2])), writedata, byteenable);
      if (resp_valid && !seen_read_resp) begin
        seen_read_resp = 1;
        tests_run++;
        if (resp_rdata !== exp_word(1)) begin tests_failed++; $display("FAIL b2b_rdata: got %h want %h", resp_rdata, exp_word(1)); end
      end
      if (req_ready && req_valid) begin
        if (first < 0) begin first = c; switch_now = 1; end
        else if (second < 0) begin second = c; stop_now = 1; end
      end
      @(negedge clk);
    end
    tests_run++;
    if (second - first !== 3) begin tests_failed++; $display("FAIL b2b_spacing: got %0d want 3", second - first); end
    tests_run++;
    if (overlaps !== 0) begin tests_failed++; $display("FAIL b2b_overlap: got %0d want 0", overlaps); end
    tests_run++;
    if (slave_word(2) !== exp_word(2)) begin tests_failed++; $display("FAIL b2b_memory: got %h want %h", slave_word(2), exp_word(2)); end
  endtask

  task automatic test_random();
    logic wr;
    logic [3:0] be;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      be = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      do_txn("random", wr, 32'($urandom_range(0, 63)), $urandom, be, int'($urandom_range(0, 6)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
